// File: rtl/switch_updown_counter.sv
`default_nettype none
// ============================================================================
// Module  : switch_updown_counter
// Purpose : Two debounced switches step a two-digit BCD count (00-99) up/down,
//           with optional hold-to-repeat (SWITCH_UPDOWN_COUNTER_AUTOREPEAT_EN).
// Revision: 1.0  initial release
// ============================================================================
module switch_updown_counter #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_RATE    = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_Up,
    input  logic       i_Switch_Dn,
    output logic [3:0] o_Ones,
    output logic [3:0] o_Tens,
    output logic       o_Step
);

    localparam int              DB_W      = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic C_DIR_UP = 1'b0;
    localparam logic C_DIR_DN = 1'b1;

    if (DEBOUNCE_LIMIT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("switch_updown_counter: all timing parameters must be >= 1");
    end

    // Index 0 is the Up switch, index 1 the Dn switch.
    logic [1:0]      w_raw;
    logic [1:0]      r_db_level;
    logic [1:0]      r_db_q;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      w_press;

    assign w_raw   = {i_Switch_Dn, i_Switch_Up};
    assign w_press = r_db_level & ~r_db_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_db_level <= 2'b00;
            r_db_q     <= 2'b00;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_db_q <= r_db_level;
            for (int i = 0; i < 2; i++) begin
                if (w_raw[i] == r_db_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == C_DB_LAST) begin
                    r_db_level[i] <= w_raw[i];
                    r_db_cnt[i]   <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_dir;
    logic       w_dir_nxt;
    logic       w_dir_held;
    logic       w_step;
    logic       w_timer_clr;

    assign w_dir_held = (r_dir == C_DIR_UP) ? r_db_level[0] : r_db_level[1];

`ifdef SWITCH_UPDOWN_COUNTER_AUTOREPEAT_EN
    localparam int            C_TMAX_I     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            TW           = $clog2(C_TMAX_I + 1);
    localparam logic [TW-1:0] C_TMAX       = TW'(C_TMAX_I);
    localparam logic [TW-1:0] C_DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] C_RATE_LAST  = TW'(REPEAT_RATE - 1);

    logic [TW-1:0] r_timer;

    // Saturating so the timer can never wrap into a spurious terminal count.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || w_timer_clr || r_state == S_IDLE) begin
            r_timer <= '0;
        end else if (r_timer != C_TMAX) begin
            r_timer <= r_timer + 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        w_timer_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press[0]) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = C_DIR_UP;
                    w_timer_clr = 1'b1;
                    w_state_nxt = S_DELAY;
                end else if (w_press[1]) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = C_DIR_DN;
                    w_timer_clr = 1'b1;
                    w_state_nxt = S_DELAY;
                end
            end
            S_DELAY: begin
                if (!w_dir_held) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef SWITCH_UPDOWN_COUNTER_AUTOREPEAT_EN
                else if (r_timer == C_DELAY_LAST) begin
                    w_step      = 1'b1;
                    w_timer_clr = 1'b1;
                    w_state_nxt = S_REPEAT;
                end
`endif
            end
            S_REPEAT: begin
                if (!w_dir_held) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef SWITCH_UPDOWN_COUNTER_AUTOREPEAT_EN
                else if (r_timer == C_RATE_LAST) begin
                    w_step      = 1'b1;
                    w_timer_clr = 1'b1;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    logic [3:0] w_ones_nxt;
    logic [3:0] w_tens_nxt;

    always_comb begin
        w_ones_nxt = o_Ones;
        w_tens_nxt = o_Tens;
        if (w_dir_nxt == C_DIR_UP) begin
            if (o_Ones == 4'd9) begin
                w_ones_nxt = 4'd0;
                w_tens_nxt = (o_Tens == 4'd9) ? 4'd0 : o_Tens + 4'd1;
            end else begin
                w_ones_nxt = o_Ones + 4'd1;
            end
        end else begin
            if (o_Ones == 4'd0) begin
                w_ones_nxt = 4'd9;
                w_tens_nxt = (o_Tens == 4'd0) ? 4'd9 : o_Tens - 4'd1;
            end else begin
                w_ones_nxt = o_Ones - 4'd1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= S_IDLE;
            r_dir   <= C_DIR_UP;
            o_Ones  <= 4'd0;
            o_Tens  <= 4'd0;
            o_Step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            o_Step  <= w_step;
            if (w_step) begin
                o_Ones <= w_ones_nxt;
                o_Tens <= w_tens_nxt;
            end
        end
    end

endmodule
`default_nettype wire
